// File: rtl/periph_err_slave.sv
// Error slave for the peripheral crossbar: grants every request it has room for and answers
// each one with an error response after RESP_LATENCY cycles. Define PERIPH_ERR_SLAVE_IRQ_EN for the capture IRQ.
module periph_err_slave #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int BE_WIDTH     = 4,
  parameter int ID_WIDTH     = 9,
  parameter int RESP_LATENCY = 1,
  parameter int FIFO_DEPTH   = 2,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA = 32'hBADACCE5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic [ADDR_WIDTH-1:0] add_i,
  input  logic                  we_n_i,
  input  logic [BE_WIDTH-1:0]   be_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ID_WIDTH-1:0]   id_i,
  output logic                  gnt_o,
  output logic                  r_valid_o,
  output logic                  r_opc_o,
  output logic [ID_WIDTH-1:0]   r_id_o,
  output logic [DATA_WIDTH-1:0] r_rdata_o,
  output logic                  err_valid_o,
  output logic [ADDR_WIDTH-1:0] err_addr_o,
  output logic [ID_WIDTH-1:0]   err_id_o,
  output logic                  err_we_o,
  output logic [15:0]           err_cnt_o,
  input  logic                  err_clr_i,
  output logic                  irq_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = 3;
  localparam logic [TW-1:0] TMR_INIT = TW'(RESP_LATENCY);

  typedef enum logic {IDLE, CAPTURED} cap_state_e;

  logic                unused_ok;
  logic                accept, pop, capture;
  logic [CW-1:0]       count_q, count_d, wr_pos;
  logic [ID_WIDTH-1:0] id_q [FIFO_DEPTH];
  logic [ID_WIDTH-1:0] id_d [FIFO_DEPTH];
  logic [TW-1:0]       tmr_q [FIFO_DEPTH];
  logic [TW-1:0]       tmr_d [FIFO_DEPTH];
  logic [ID_WIDTH-1:0] id_nx [FIFO_DEPTH+1];
  logic [TW-1:0]       tmr_nx [FIFO_DEPTH+1];
  cap_state_e          state_q, state_d;

  assign unused_ok = ^{be_i, wdata_i};

  // No bypass: a full FIFO refuses even when its head leaves this cycle.
  assign gnt_o  = count_q < CW'(FIFO_DEPTH);
  assign accept = req_i & gnt_o;
  // Entries are age-ordered and share one latency, so only the head can expire.
  assign pop    = (count_q != '0) && (tmr_q[0] == TW'(1));
  assign wr_pos = count_q - CW'(pop);

  assign r_valid_o = pop;
  assign r_opc_o   = pop;
  assign r_id_o    = pop ? id_q[0] : '0;
  assign r_rdata_o = pop ? ERR_RDATA : '0;

  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      id_nx[i]  = id_q[i];
      tmr_nx[i] = tmr_q[i];
    end
    id_nx[FIFO_DEPTH]  = '0;
    tmr_nx[FIFO_DEPTH] = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      id_d[i]  = pop ? id_nx[i+1]  : id_nx[i];
      tmr_d[i] = pop ? tmr_nx[i+1] : tmr_nx[i];
      if (tmr_d[i] != '0) tmr_d[i] = tmr_d[i] - TW'(1);
      if (accept && (CW'(i) == wr_pos)) begin
        id_d[i]  = id_i;
        tmr_d[i] = TMR_INIT;
      end
    end
    count_d = count_q + CW'(accept) - CW'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        id_q[i]  <= '0;
        tmr_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        id_q[i]  <= id_d[i];
        tmr_q[i] <= tmr_d[i];
      end
    end
  end

  // A clear coinciding with an accept re-arms the capture with the new request.
  assign capture = accept & ((state_q == IDLE) | err_clr_i);

  always_comb begin
    state_d = state_q;
    if (capture)        state_d = CAPTURED;
    else if (err_clr_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  assign err_valid_o = (state_q == CAPTURED);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_addr_o <= '0;
      err_id_o   <= '0;
      err_we_o   <= 1'b0;
    end else if (capture) begin
      err_addr_o <= add_i;
      err_id_o   <= id_i;
      err_we_o   <= ~we_n_i;
    end else if (err_clr_i) begin
      err_addr_o <= '0;
      err_id_o   <= '0;
      err_we_o   <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)                              err_cnt_o <= '0;
    else if (err_clr_i)                     err_cnt_o <= {15'd0, accept};
    else if (accept && err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'd1;
  end

`ifdef PERIPH_ERR_SLAVE_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) irq_q <= 1'b0;
    else       irq_q <= capture;
  end
  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_periph_err_slave.sv
// Bench for periph_err_slave: three instances (L=1/D=2, L=2/D=3, L=3/D=2) on shared inputs,
// each checked against an acceptance-history model of the response and capture rules.
module tb_periph_err_slave;

`ifdef PERIPH_ERR_SLAVE_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req, we_n, clr;
  logic [31:0] add, wdata;
  logic [3:0]  be;
  logic [8:0]  id;

  logic        gnt [3], rv [3], ropc [3], ev [3], ewe [3], irq [3];
  logic [8:0]  rid [3], eid [3];
  logic [31:0] rdata [3], eaddr [3];
  logic [15:0] ecnt [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    periph_err_slave #(.RESP_LATENCY(g + 1), .FIFO_DEPTH(g == 1 ? 3 : 2)) u_dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add), .we_n_i(we_n), .be_i(be),
      .wdata_i(wdata), .id_i(id), .gnt_o(gnt[g]), .r_valid_o(rv[g]), .r_opc_o(ropc[g]),
      .r_id_o(rid[g]), .r_rdata_o(rdata[g]), .err_valid_o(ev[g]), .err_addr_o(eaddr[g]),
      .err_id_o(eid[g]), .err_we_o(ewe[g]), .err_cnt_o(ecnt[g]), .err_clr_i(clr), .irq_o(irq[g])
    );
  end

  // Model: hist[k][c&7] holds the id accepted by instance k in cycle c, or -1.
  int          hist [3][8];
  bit          m_cap [3], m_we [3], m_irq [3];
  logic [31:0] m_addr [3];
  logic [8:0]  m_id [3];
  int          m_cnt [3];
  int          cyc, checks, errors;

  function automatic int lat(int k);   return k + 1;            endfunction
  function automatic int depth(int k); return (k == 1) ? 3 : 2; endfunction

  // Everything accepted in the last L cycles still occupies the FIFO this cycle.
  function automatic int occ(int k);
    int n = 0;
    for (int d = 1; d <= lat(k); d++) if (hist[k][(cyc - d) & 7] >= 0) n++;
    return n;
  endfunction

  function automatic logic [43:0] exp_resp(int k);
    int h = hist[k][(cyc - lat(k)) & 7];
    return {occ(k) < depth(k), h >= 0, h >= 0, (h >= 0) ? 9'(h) : 9'h0,
            (h >= 0) ? 32'hBADACCE5 : 32'h0};
  endfunction

  function automatic logic [59:0] exp_cap(int k);
    return {m_cap[k], m_addr[k], m_id[k], m_we[k], 16'(m_cnt[k]), m_irq[k]};
  endfunction

  task automatic model_clear(int k);
    for (int j = 0; j < 8; j++) hist[k][j] = -1;
    m_cap[k] = 0; m_addr[k] = '0; m_id[k] = '0; m_we[k] = 0; m_cnt[k] = 0; m_irq[k] = 0;
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      bit acc, cap;
      acc = req && (occ(k) < depth(k));
      hist[k][cyc & 7] = acc ? int'(id) : -1;
      cap = acc && (!m_cap[k] || clr);
      if (cap) begin
        m_cap[k] = 1; m_addr[k] = add; m_id[k] = id; m_we[k] = !we_n;
      end else if (clr) begin
        m_cap[k] = 0; m_addr[k] = '0; m_id[k] = '0; m_we[k] = 0;
      end
      if (clr)                           m_cnt[k] = acc ? 1 : 0;
      else if (acc && m_cnt[k] < 65535)  m_cnt[k]++;
      m_irq[k] = IRQ_EN && cap;
      if (rst) model_clear(k);
    end
  endtask

  task automatic setup(input bit r, input bit q, input bit wn, input bit c,
                       input logic [31:0] a, input logic [8:0] i);
    rst = r; req = q; we_n = wn; clr = c; add = a; id = i;
    be = 4'($urandom); wdata = $urandom;
    @(negedge clk);
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    setup(1, 0, 1, 0, 0, 0); advance();
    setup(0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({gnt[k], rv[k], ropc[k], rid[k], rdata[k], ev[k], eaddr[k], eid[k], ewe[k], ecnt[k], irq[k]}
          !== {1'b1, 103'd0}) begin
        errors++;
        $display("FAIL reset_state[%0d] got gnt=%b rv=%b opc=%b rid=%h rdata=%h ev=%b addr=%h eid=%h we=%b cnt=%h irq=%b want gnt=1 rest 0",
                 k, gnt[k], rv[k], ropc[k], rid[k], rdata[k], ev[k], eaddr[k], eid[k], ewe[k], ecnt[k], irq[k]);
      end
    end
    advance();
  endtask

  task automatic test_single_read();
    for (int n = 0; n < 8; n++) begin setup(0, 0, 1, 0, 0, 0); advance(); end
    setup(0, 1, 1, 0, 32'h1020_4000, 9'h004);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (gnt[k] !== 1'b1) begin errors++; $display("FAIL read_gnt[%0d] got %b want 1", k, gnt[k]); end
    end
    advance();
    setup(0, 0, 1, 0, 0, 0);
    checks++;
    if ({rv[0], ropc[0], rid[0], rdata[0], ev[0], eaddr[0], ewe[0], ecnt[0], irq[0]} !==
        {1'b1, 1'b1, 9'h004, 32'hBADACCE5, 1'b1, 32'h1020_4000, 1'b0, 16'd1, IRQ_EN}) begin
      errors++;
      $display("FAIL read_resp got rv=%b opc=%b rid=%h rdata=%h ev=%b addr=%h we=%b cnt=%h irq=%b want 1 1 004 badacce5 1 10204000 0 0001 %b",
               rv[0], ropc[0], rid[0], rdata[0], ev[0], eaddr[0], ewe[0], ecnt[0], irq[0], IRQ_EN);
    end
    checks++;
    if ({rv[1], rv[2]} !== 2'b00) begin errors++; $display("FAIL read_early got rv1=%b rv2=%b want 0 0", rv[1], rv[2]); end
    for (int k = 1; k < 3; k++) begin
      advance(); setup(0, 0, 1, 0, 0, 0);
      checks++;
      if ({rv[k], rid[k]} !== {1'b1, 9'h004}) begin
        errors++; $display("FAIL read_lat[%0d] got rv=%b rid=%h want 1 004", k, rv[k], rid[k]);
      end
    end
    advance();
  endtask

  task automatic test_back_to_back();
    setup(1, 0, 1, 0, 0, 0); advance();
    for (int n = 0; n < 12; n++) begin
      if (n < 6) setup(0, 1, 1, 0, $urandom, 9'(1 << n));
      else       setup(0, 0, 1, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({gnt[k], rv[k], ropc[k], rid[k], rdata[k]} !== exp_resp(k)) begin
          errors++;
          $display("FAIL b2b_resp[%0d] cyc %0d got %h want %h", k, n,
                   {gnt[k], rv[k], ropc[k], rid[k], rdata[k]}, exp_resp(k));
        end
      end
      advance();
    end
    setup(0, 0, 1, 0, 0, 0);
    checks++;
    if ({ecnt[0], eid[0], ecnt[1], eid[1], ecnt[2], eid[2]} !==
        {16'd6, 9'h001, 16'd6, 9'h001, 16'd4, 9'h001}) begin
      errors++;
      $display("FAIL b2b_counts got %h/%h %h/%h %h/%h want 0006/001 0006/001 0004/001",
               ecnt[0], eid[0], ecnt[1], eid[1], ecnt[2], eid[2]);
    end
    advance();
  endtask

  task automatic test_clr_capture();
    setup(0, 1, 0, 1, 32'h1020_5000, 9'h100);
    advance();
    setup(0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({ev[k], eaddr[k], eid[k], ewe[k], ecnt[k], irq[k]} !==
          {1'b1, 32'h1020_5000, 9'h100, 1'b1, 16'd1, IRQ_EN}) begin
        errors++;
        $display("FAIL clr_capture[%0d] got ev=%b addr=%h id=%h we=%b cnt=%h irq=%b want 1 10205000 100 1 0001 %b",
                 k, ev[k], eaddr[k], eid[k], ewe[k], ecnt[k], irq[k], IRQ_EN);
      end
    end
    advance();
    setup(0, 0, 1, 0, 0, 0);
    checks++;
    if ({irq[0], irq[1], irq[2]} !== 3'b000) begin
      errors++; $display("FAIL irq_pulse_width got %b%b%b want 000", irq[0], irq[1], irq[2]);
    end
    advance();
  endtask

  task automatic test_reset_pending();
    setup(0, 1, 1, 0, $urandom, 9'h002); advance();
    setup(0, 1, 1, 0, $urandom, 9'h008); advance();
    setup(1, 0, 1, 0, 0, 0); advance();
    for (int n = 0; n < 5; n++) begin
      setup(0, 0, 1, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({rv[k], gnt[k], ev[k]} !== 3'b010) begin
          errors++;
          $display("FAIL reset_pending[%0d] cyc %0d got rv=%b gnt=%b ev=%b want 0 1 0", k, n, rv[k], gnt[k], ev[k]);
        end
      end
      advance();
    end
  endtask

  task automatic test_saturate();
    setup(0, 0, 1, 1, 0, 0); advance();
    for (int n = 0; n < 65534; n++) begin setup(0, 1, 1, 0, 32'(n), 9'h001); advance(); end
    for (int n = 0; n < 3; n++) begin
      setup(0, 1, 1, 0, 32'(n), 9'h001);
      if (n == 0) begin
        checks++;
        if (ecnt[0] !== 16'hFFFE) begin errors++; $display("FAIL sat_pre got %h want fffe", ecnt[0]); end
      end
      advance();
    end
    setup(0, 0, 1, 0, 0, 0);
    checks++;
    if ({ecnt[0], ecnt[1]} !== {16'hFFFF, 16'hFFFF}) begin
      errors++; $display("FAIL sat_hold got %h %h want ffff ffff", ecnt[0], ecnt[1]);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({ev[k], eaddr[k], eid[k], ewe[k], ecnt[k], irq[k]} !== exp_cap(k)) begin
        errors++;
        $display("FAIL sat_cap[%0d] got %h want %h", k,
                 {ev[k], eaddr[k], eid[k], ewe[k], ecnt[k], irq[k]}, exp_cap(k));
      end
    end
    advance();
  endtask

  task automatic test_random();
    setup(1, 0, 1, 0, 0, 0); advance();
    for (int n = 0; n < 400; n++) begin
      setup($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 7) == 0, $urandom, 9'(1 << $urandom_range(0, 8)));
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({gnt[k], rv[k], ropc[k], rid[k], rdata[k]} !== exp_resp(k)) begin
          errors++;
          $display("FAIL rand_resp[%0d] cyc %0d got %h want %h", k, n,
                   {gnt[k], rv[k], ropc[k], rid[k], rdata[k]}, exp_resp(k));
        end
        checks++;
        if ({ev[k], eaddr[k], eid[k], ewe[k], ecnt[k], irq[k]} !== exp_cap(k)) begin
          errors++;
          $display("FAIL rand_cap[%0d] cyc %0d got %h want %h", k, n,
                   {ev[k], eaddr[k], eid[k], ewe[k], ecnt[k], irq[k]}, exp_cap(k));
        end
      end
      advance();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = 1'b0; we_n = 1'b1; clr = 1'b0; add = '0; id = '0; be = '0; wdata = '0;
    cyc = 0; checks = 0; errors = 0;
    for (int k = 0; k < 3; k++) model_clear(k);
    test_reset();
    test_single_read();
    test_back_to_back();
    test_clr_capture();
    test_reset_pending();
    test_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
